// File: rtl/run_step_ctrl_pkg.sv
// Shared definitions for the run/step execution controller: FSM state encoding
// and a small state-classification helper.
package run_step_ctrl_pkg;

  localparam int RCS_STATE_BIT = 2;

  typedef enum logic [RCS_STATE_BIT-1:0] {
    RCS_PAUSE  = 2'd0,
    RCS_RUN    = 2'd1,
    RCS_STEP   = 2'd2,
    RCS_HALTED = 2'd3
  } rcs_state_e;

  // States in which the CPU is allowed to advance (before halt/break gating).
  function automatic logic rcs_active(input rcs_state_e s);
    return (s == RCS_RUN) || (s == RCS_STEP);
  endfunction

endpackage

// File: rtl/run_step_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability-count debounce and a press
// pulse that stays disarmed until the input has been seen released after reset.
module btn_debounce
  import run_step_ctrl_pkg::*;
#(
  parameter int DebounceCycles = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DebounceCycles + 1);
  localparam logic [CW-1:0] LAST = CW'(DebounceCycles - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;

  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = 1'b0;
    cnt_d     = '0;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;

    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = ~level_q;
        press_d = ~level_q & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A button held through reset must be seen released for a full debounce
    // window before any press is allowed to act.
    if (!armed_q) begin
      if (!sync2_q) begin
        if (arm_cnt_q == LAST) armed_d = 1'b1;
        else                   arm_cnt_d = arm_cnt_q + 1'b1;
      end else begin
        arm_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/run_step_ctrl.sv
// Run/Step execution controller feeding the CPU clock enable, with saturating
// execution statistics. Optional breakpoint support under RUN_CTRL_BREAK_EN.
module run_step_ctrl
  import run_step_ctrl_pkg::*;
#(
  parameter int DebounceCycles = 1000000,
  parameter int CntWidth       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_run,
  input  logic                btn_step,
  input  logic                halt,
  input  logic                jumped,
  input  logic                is_branch,
  input  logic                branched,
`ifdef RUN_CTRL_BREAK_EN
  input  logic                brk_valid,
  input  logic [31:0]         brk_addr,
  input  logic [31:0]         pc,
`endif
  output logic                en,
  output logic                running,
  output logic                halted,
  output logic [CntWidth-1:0] cycle_cnt,
  output logic [CntWidth-1:0] jump_cnt,
  output logic [CntWidth-1:0] branch_cnt,
  output logic [CntWidth-1:0] taken_cnt
);

  logic run_level, run_press, step_level, step_press;
  logic run_go, step_go;
  logic brk_hit;

  rcs_state_e state_q, state_d;

  logic [CntWidth-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CntWidth-1:0] jump_cnt_q, jump_cnt_d;
  logic [CntWidth-1:0] branch_cnt_q, branch_cnt_d;
  logic [CntWidth-1:0] taken_cnt_q, taken_cnt_d;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v,
                                                  input logic inc);
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_run_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_run),
    .level (run_level),
    .press (run_press)
  );

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .level (step_level),
    .press (step_press)
  );

  // A press pulse always coincides with its debounced level being high.
  assign run_go  = run_press & run_level;
  assign step_go = step_press & step_level;

`ifdef RUN_CTRL_BREAK_EN
  logic first_run_q, first_run_d;

  // Skipping the compare on the first RUN cycle lets a resume execute the
  // instruction that triggered the break.
  assign brk_hit = (state_q == RCS_RUN) && !first_run_q && brk_valid && (pc == brk_addr);

  always_comb first_run_d = (state_d == RCS_RUN) && (state_q != RCS_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_run_q <= 1'b0;
    else        first_run_q <= first_run_d;
  end
`else
  assign brk_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    en      = rcs_active(state_q) && !halt && !brk_hit;

    unique case (state_q)
      RCS_PAUSE: begin
        if (run_go)       state_d = RCS_RUN;
        else if (step_go) state_d = RCS_STEP;
      end
      RCS_RUN: begin
        if (halt)         state_d = RCS_HALTED;
        else if (brk_hit) state_d = RCS_PAUSE;
        else if (run_go)  state_d = RCS_PAUSE;
      end
      RCS_STEP: begin
        state_d = halt ? RCS_HALTED : RCS_PAUSE;
      end
      RCS_HALTED: begin
        state_d = RCS_HALTED;
      end
      default: state_d = RCS_PAUSE;
    endcase

    cycle_cnt_d  = sat_inc(cycle_cnt_q,  en);
    jump_cnt_d   = sat_inc(jump_cnt_q,   en & jumped);
    branch_cnt_d = sat_inc(branch_cnt_q, en & is_branch);
    taken_cnt_d  = sat_inc(taken_cnt_q,  en & branched);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RCS_PAUSE;
      cycle_cnt_q  <= '0;
      jump_cnt_q   <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign running    = (state_q == RCS_RUN);
  assign halted     = (state_q == RCS_HALTED);
  assign cycle_cnt  = cycle_cnt_q;
  assign jump_cnt   = jump_cnt_q;
  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule
